// File: rtl/detector_rgb_ball_moor_non_overlap.sv
// Moore FSM that flags the ball colour sequence R, G, B on consecutive cycles.
// Matching is non-overlapping: after a detection the match history is cleared.
// det is high for the cycle in which the FSM sits in S_DET.
module detector_rgb_ball_moor_non_overlap #(
    parameter logic [1:0] R_CODE = 2'b00,
    parameter logic [1:0] G_CODE = 2'b01,
    parameter logic [1:0] B_CODE = 2'b10
) (
    output logic       det,
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] inp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_R    = 2'd1,
        S_RG   = 2'd2,
        S_DET  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // State register; det is registered from the next state so it tracks S_DET exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            det   <= 1'b0;
        end else begin
            state <= state_nxt;
            det   <= (state_nxt == S_DET);
        end
    end

    // Next-state logic; any unmatched code (incl. 2'b11 or X/Z) takes the no-match path
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: begin
                if (inp == R_CODE) state_nxt = S_R;
                else               state_nxt = S_IDLE;
            end
            S_R: begin
                if (inp == R_CODE)      state_nxt = S_R;
                else if (inp == G_CODE) state_nxt = S_RG;
                else                    state_nxt = S_IDLE;
            end
            S_RG: begin
                if (inp == B_CODE)      state_nxt = S_DET;
                else if (inp == R_CODE) state_nxt = S_R;
                else                    state_nxt = S_IDLE;
            end
            S_DET: begin
                if (inp == R_CODE) state_nxt = S_R;
                else               state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_detector_rgb_ball_moor_non_overlap.sv
// Directed bench for the R,G,B non-overlapping Moore detector.
module tb_detector_rgb_ball_moor_non_overlap;

    localparam logic [1:0] R  = 2'b00;
    localparam logic [1:0] G  = 2'b01;
    localparam logic [1:0] B  = 2'b10;
    localparam logic [1:0] NB = 2'b11;

    logic       clk;
    logic       rst;
    logic [1:0] inp;
    logic       det;

    int checks = 0;
    int errors = 0;

    detector_rgb_ball_moor_non_overlap dut (
        .det (det),
        .clk (clk),
        .rst (rst),
        .inp (inp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare det against the hand-computed value
    task automatic check(input logic exp, input string tag);
        checks++;
        assert (det === exp) else begin
            errors++;
            $error("FAIL %s det=%b expected=%b", tag, det, exp);
        end
    endtask

    // Drive one ball away from the edge, then check det just after the sampling edge
    task automatic step(input logic [1:0] v, input logic exp, input string tag);
        @(negedge clk);
        inp = v;
        @(posedge clk);
        #1;
        check(exp, tag);
    endtask

    initial begin
        rst = 1'b0;
        inp = R;
        #1;
        check(1'b0, "reset_state");
        // R held during reset must be ignored
        @(posedge clk); #1; check(1'b0, "reset_hold_r0");
        @(posedge clk); #1; check(1'b0, "reset_hold_r1");
        @(negedge clk);
        inp = G;
        rst = 1'b1;
        step(B,  1'b0, "post_reset_b_no_history");

        // Basic R,G,B
        step(R,  1'b0, "rgb_r");
        step(G,  1'b0, "rgb_g");
        step(B,  1'b1, "rgb_b_det");
        // R,B -> idle; G,B afterwards must not detect
        step(R,  1'b0, "rb_r");
        step(B,  1'b0, "rb_b");
        step(G,  1'b0, "rb_idle_g");
        step(B,  1'b0, "rb_idle_b");
        // B,R,G leaves S_RG; following B detects
        step(B,  1'b0, "brg_b");
        step(R,  1'b0, "brg_r");
        step(G,  1'b0, "brg_g");
        step(B,  1'b1, "brg_then_b_det");
        // Repeated R restarts the match
        step(R,  1'b0, "rrgb_r0");
        step(R,  1'b0, "rrgb_r1");
        step(G,  1'b0, "rrgb_g");
        step(B,  1'b1, "rrgb_b_det");
        // Back-to-back sequences: two pulses 3 cycles apart
        step(R,  1'b0, "b2b_r0");
        step(G,  1'b0, "b2b_g0");
        step(B,  1'b1, "b2b_det0");
        step(R,  1'b0, "b2b_r1_pulse_end");
        step(G,  1'b0, "b2b_g1");
        step(B,  1'b1, "b2b_det1");
        step(NB, 1'b0, "b2b_after_nb");
        // Invalid code breaks the sequence
        step(R,  1'b0, "rgnb_r");
        step(G,  1'b0, "rgnb_g");
        step(NB, 1'b0, "rgnb_nb");
        step(B,  1'b0, "rgnb_b");
        // X input takes the no-match path
        step(R,     1'b0, "rgx_r");
        step(G,     1'b0, "rgx_g");
        step(2'bxx, 1'b0, "rgx_x");
        step(B,     1'b0, "rgx_b");
        step(2'bxx, 1'b0, "idle_x");
        step(R,     1'b0, "x_recover_r");
        step(G,     1'b0, "x_recover_g");
        step(B,     1'b1, "x_recover_det");

        // Reset while in S_RG discards history
        step(R,  1'b0, "rst_rg_r");
        step(G,  1'b0, "rst_rg_g");
        @(negedge clk);
        inp = B;
        rst = 1'b0;
        #1;
        check(1'b0, "rst_rg_low");
        @(posedge clk); #1; check(1'b0, "rst_rg_hold_b");
        @(negedge clk);
        rst = 1'b1;
        step(B,  1'b0, "rst_rg_then_b");

        // Async reset drops det without a clock edge
        step(R,  1'b0, "async_r");
        step(G,  1'b0, "async_g");
        step(B,  1'b1, "async_det");
        #2;
        rst = 1'b0;
        #1;
        check(1'b0, "async_det_drop");
        @(negedge clk);
        rst = 1'b1;
        inp = NB;
        step(R,  1'b0, "recover_r");
        step(G,  1'b0, "recover_g");
        step(B,  1'b1, "recover_det");
        step(G,  1'b0, "recover_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
